branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage MIPS pipeline. It sits beside the IF stage. Each cycle it looks up the fetch PC in a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB), and returns the predicted next PC. It is updated by the EX stage when a branch resolves, and it raises `mispredict` with the recovery PC that the pipeline uses to flush IF/ID and redirect fetch.

---
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor + BTB beside IF: zero-cycle lookup/resolve, updates visible next cycle; never stalls.
// Optional saturating resolve/mispredict statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        predicted_taken,
  output logic [31:0] pred_next_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_actual_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] recovery_pc,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  logic [1:0]       ctr    [N];
  logic             valid  [N];
  logic [TAG_W-1:0] tag    [N];
  logic [31:0]      target [N];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit, upd;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  // Lookup
  assign if_hit          = valid[if_idx] && (tag[if_idx] == if_tag);
  assign predicted_taken = if_hit && ctr[if_idx][1];
  assign pred_next_pc    = predicted_taken ? target[if_idx] : (if_pc + 32'd4);

  // Resolve
  assign upd         = ex_valid && ex_is_branch;
  assign ex_hit      = valid[ex_idx] && (tag[ex_idx] == ex_tag);
  assign mispredict  = upd && ((ex_actual_taken != ex_pred_taken) ||
                               (ex_actual_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign recovery_pc = ex_actual_taken ? ex_target : (ex_pc + 32'd4);

  // Table update; a not-taken miss leaves the table untouched so cold branches cost nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        ctr[i]    <= 2'b01;
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (upd) begin
      if (ex_hit) begin
        if (ex_actual_taken) begin
          if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
          target[ex_idx] <= ex_target;
        end else if (ctr[ex_idx] != 2'b00) begin
          ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
        end
      end else if (ex_actual_taken) begin
        valid[ex_idx]  <= 1'b1;
        tag[ex_idx]    <= ex_tag;
        target[ex_idx] <= ex_target;
        ctr[ex_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] br_cnt, mis_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt  <= 16'h0000;
      mis_cnt <= 16'h0000;
    end else begin
      if (upd && (br_cnt != 16'hFFFF))        br_cnt  <= br_cnt + 16'd1;
      if (mispredict && (mis_cnt != 16'hFFFF)) mis_cnt <= mis_cnt + 16'd1;
    end
  end

  assign branch_count     = br_cnt;
  assign mispredict_count = mis_cnt;
`else
  assign branch_count     = 16'h0000;
  assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, resolve, counter saturation, aliasing, reset, stats.
module tb_branch_predictor;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        predicted_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid, ex_is_branch, ex_actual_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] recovery_pc;
  logic [15:0] branch_count, mispredict_count;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .predicted_taken(predicted_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_actual_taken(ex_actual_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .recovery_pc(recovery_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc);
    if_pc = pc;
    #1;
    check({name, "_taken"}, {31'd0, predicted_taken}, {31'd0, exp_t});
    check({name, "_next"}, pred_next_pc, exp_pc);
  endtask

  task automatic check_stats(input string name, input int br, input int mis);
    check({name, "_br"},  {16'd0, branch_count},     STATS ? br  : 0);
    check({name, "_mis"}, {16'd0, mispredict_count}, STATS ? mis : 0);
  endtask

  // Drives one EX resolve, checks the combinational result, then takes the edge.
  task automatic resolve(input string name, input logic [31:0] pc, input logic act,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_mis, input logic [31:0] exp_rec);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_actual_taken = act;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    check({name, "_mis"}, {31'd0, mispredict}, {31'd0, exp_mis});
    check({name, "_rec"}, recovery_pc, exp_rec);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_pc = 32'h10;
    ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_actual_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    #2;
    lookup("rst", 32'h10, 1'b0, 32'h14);
    check("rst_mis", {31'd0, mispredict}, 32'd0);
    check_stats("rst", 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First taken resolve allocates; same-cycle lookup of the same index sees old state.
    if_pc = 32'h10;
    #1;
    check("nobypass_pre", {31'd0, predicted_taken}, 32'd0);
    resolve("alloc", 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1, 32'h40);
    lookup("after_alloc", 32'h10, 1'b1, 32'h40);

    // Saturate at 11, then two not-taken steps leave 01.
    resolve("t2", 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
    resolve("t3", 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
    resolve("t4", 32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h40);
    resolve("nt1", 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
    lookup("after_nt1", 32'h10, 1'b1, 32'h40);
    resolve("nt2", 32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h14);
    lookup("after_nt2", 32'h10, 1'b0, 32'h14);
    check_stats("mid", 6, 3);

    // Aliasing: 0x50 shares index 4 with 0x10 and evicts it.
    resolve("alias", 32'h50, 1'b1, 32'h80, 1'b0, 32'h54, 1'b1, 32'h80);
    lookup("alias_old", 32'h10, 1'b0, 32'h14);
    lookup("alias_new", 32'h50, 1'b1, 32'h80);
    resolve("nt_miss", 32'h90, 1'b0, 32'hA0, 1'b0, 32'h94, 1'b0, 32'h94);
    lookup("nt_miss_keep", 32'h50, 1'b1, 32'h80);
    lookup("nt_miss_none", 32'h90, 1'b0, 32'h94);

    // Non-branch instructions never allocate nor mispredict.
    ex_valid = 1; ex_is_branch = 0; ex_pc = 32'h20; ex_actual_taken = 1;
    ex_target = 32'h99; ex_pred_taken = 0; ex_pred_target = 32'h24;
    #1;
    check("nonbr_mis", {31'd0, mispredict}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 0;
    lookup("nonbr", 32'h20, 1'b0, 32'h24);

    // Wrong target on a correctly predicted taken branch.
    resolve("realloc", 32'h10, 1'b1, 32'h40, 1'b0, 32'h14, 1'b1, 32'h40);
    resolve("wrongtgt", 32'h10, 1'b1, 32'h60, 1'b1, 32'h40, 1'b1, 32'h60);
    lookup("newtgt", 32'h10, 1'b1, 32'h60);
    check_stats("pre_rst", 10, 6);

    // Mid-run reset: state gone immediately; update held across a low-reset edge is dropped.
    if_pc = 32'h10;
    rst = 1'b0;
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h30; ex_actual_taken = 1;
    ex_target = 32'h70; ex_pred_taken = 0; ex_pred_target = 32'h34;
    #1;
    check("rst_pred", {31'd0, predicted_taken}, 32'd0);
    check("rst_next", pred_next_pc, 32'h14);
    check("rst_mis_comb", {31'd0, mispredict}, 32'd1);
    check_stats("in_rst", 0, 0);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 0;
    lookup("rst_drop", 32'h30, 1'b0, 32'h34);
    check_stats("post_rst", 0, 0);

    // Five resolves, two mispredicts.
    resolve("s1", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    resolve("s2", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    resolve("s3", 32'h104, 1'b0, 32'h300, 1'b0, 32'h108, 1'b0, 32'h108);
    resolve("s4", 32'h108, 1'b0, 32'h300, 1'b0, 32'h10C, 1'b0, 32'h10C);
    resolve("s5", 32'h104, 1'b1, 32'h300, 1'b0, 32'h108, 1'b1, 32'h300);
    check_stats("stats", 5, 2);
    lookup("s_pred", 32'h104, 1'b1, 32'h300);

    // PC+4 wraps.
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
